// File: rtl/ycr_tcm_dmem_arb.sv
// Arbiter feeding the TCM data port from the core dmem interface and a Wishbone slave port.
// Converts Wishbone byte lanes to width/offset and bounds every response wait with a timeout.
module ycr_tcm_dmem_arb #(
  parameter logic [31:0] TCM_BASE     = 32'h0C48_0000,
  parameter int unsigned RESP_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // core dmem
  input  logic        core_req,
  input  logic        core_cmd,
  input  logic [1:0]  core_width,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_req_ack,
  output logic [31:0] core_rdata,
  output logic [1:0]  core_resp,
  // Wishbone slave
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  // TCM dmem
  output logic        tcm_req,
  output logic        tcm_cmd,
  output logic [1:0]  tcm_width,
  output logic [31:0] tcm_addr,
  output logic [31:0] tcm_wdata,
  input  logic        tcm_req_ack,
  input  logic [31:0] tcm_rdata,
  input  logic [1:0]  tcm_resp
);

  localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCReq  = 3'd1;
  localparam logic [2:0] StCResp = 3'd2;
  localparam logic [2:0] StWReq  = 3'd3;
  localparam logic [2:0] StWResp = 3'd4;
  localparam logic [2:0] StWDone = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_state_d;
  logic          r_last_wb;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_wb_off;
  logic [1:0]    r_wb_width;
  logic          r_wb_err;
  logic [31:0]   r_wb_dat;

  logic          w_wb_pend;
  logic          w_grant_wb;
  logic          w_sel_ok;
  logic [1:0]    w_sel_width;
  logic [1:0]    w_sel_off;
  logic          w_timeout;
  logic          w_resp_vld;
  logic [4:0]    w_shamt;

  assign w_wb_pend  = wb_cyc_i & wb_stb_i;
  // Round robin: Wishbone wins a tie only if the core was served last.
  assign w_grant_wb = w_wb_pend & (~core_req | ~r_last_wb);
  assign w_timeout  = (r_timer == TW'(RESP_TIMEOUT));
  assign w_resp_vld = (tcm_resp != 2'b00);
  assign w_shamt    = {r_wb_off, 3'b000};

  always_comb begin
    w_sel_ok    = 1'b1;
    w_sel_width = 2'd0;
    w_sel_off   = 2'd0;
    case (wb_sel_i)
      4'b1111: w_sel_width = 2'd2;
      4'b0011: w_sel_width = 2'd1;
      4'b1100: begin
        w_sel_width = 2'd1;
        w_sel_off   = 2'd2;
      end
      4'b0001: w_sel_off = 2'd0;
      4'b0010: w_sel_off = 2'd1;
      4'b0100: w_sel_off = 2'd2;
      4'b1000: w_sel_off = 2'd3;
      default: w_sel_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant_wb)    w_state_d = w_sel_ok ? StWReq : StWDone;
        else if (core_req) w_state_d = StCReq;
      end
      StCReq:  if (tcm_req_ack) w_state_d = StCResp;
      StCResp: if (w_timeout || w_resp_vld) w_state_d = StIdle;
      StWReq:  if (tcm_req_ack) w_state_d = StWResp;
      StWResp: if (w_timeout || w_resp_vld) w_state_d = StWDone;
      StWDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_last_wb  <= 1'b0;
      r_timer    <= '0;
      r_wb_off   <= 2'd0;
      r_wb_width <= 2'd0;
      r_wb_err   <= 1'b0;
      r_wb_dat   <= 32'h0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          r_timer <= '0;
          if (w_grant_wb) begin
            r_last_wb  <= 1'b1;
            r_wb_off   <= w_sel_off;
            r_wb_width <= w_sel_width;
            r_wb_err   <= ~w_sel_ok;
          end else if (core_req) begin
            r_last_wb <= 1'b0;
          end
        end
        StCReq, StWReq: r_timer <= '0;
        StCResp: r_timer <= r_timer + TW'(1);
        StWResp: begin
          r_timer <= r_timer + TW'(1);
          if (w_timeout) begin
            r_wb_err <= 1'b1;
          end else if (w_resp_vld) begin
            r_wb_dat <= tcm_rdata << w_shamt;
            r_wb_err <= tcm_resp[1];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tcm_req      = 1'b0;
    tcm_cmd      = 1'b0;
    tcm_width    = 2'd0;
    tcm_addr     = 32'h0;
    tcm_wdata    = 32'h0;
    core_req_ack = 1'b0;
    core_resp    = 2'b00;
    core_rdata   = 32'h0;
    case (r_state)
      StCReq: begin
        tcm_req      = 1'b1;
        tcm_cmd      = core_cmd;
        tcm_width    = core_width;
        tcm_addr     = core_addr;
        tcm_wdata    = core_wdata;
        core_req_ack = tcm_req_ack;
      end
      StWReq: begin
        tcm_req   = 1'b1;
        tcm_cmd   = wb_we_i;
        tcm_width = r_wb_width;
        tcm_addr  = {TCM_BASE[31:13], wb_adr_i[12:2], r_wb_off};
        tcm_wdata = wb_dat_i >> w_shamt;
      end
      StCResp: begin
        core_resp  = w_timeout ? 2'b10 : tcm_resp;
        core_rdata = tcm_rdata;
      end
      default: ;
    endcase
  end

  assign wb_ack_o = (r_state == StWDone) & ~r_wb_err;
  assign wb_err_o = (r_state == StWDone) & r_wb_err;
  assign wb_dat_o = r_wb_dat;

endmodule

// File: tb/tb_ycr_tcm_dmem_arb.sv
// Directed bench for ycr_tcm_dmem_arb with a small fixed-latency TCM responder.
module tb_ycr_tcm_dmem_arb;

  localparam logic [31:0] TcmBase = 32'h0C48_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_cmd = 1'b0;
  logic [1:0]  core_width = 2'd0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic        core_req_ack;
  logic [31:0] core_rdata;
  logic [1:0]  core_resp;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = 32'h0, wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        tcm_req, tcm_cmd;
  logic [1:0]  tcm_width;
  logic [31:0] tcm_addr, tcm_wdata;
  logic        tcm_req_ack;
  logic [31:0] tcm_rdata;
  logic [1:0]  tcm_resp;

  // TCM responder: accept immediately, answer two cycles after the accept.
  logic        tb_ack_en = 1'b1, tb_resp_en = 1'b1, tb_late = 1'b0;
  logic [1:0]  tb_code = 2'b01;
  logic [31:0] tb_rdata = 32'h0;
  logic        r_d1 = 1'b0, r_d2 = 1'b0;
  int          cnt_wb_ack = 0, cnt_wb_err = 0, cnt_tcm_req = 0;

  int n_chk  = 0;
  int n_fail = 0;

  assign tcm_req_ack = tcm_req & tb_ack_en;
  assign tcm_resp    = tb_late ? 2'b01 : ((r_d2 & tb_resp_en) ? tb_code : 2'b00);
  assign tcm_rdata   = tb_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_d1 <= tcm_req & tcm_req_ack;
    r_d2 <= r_d1;
    if (wb_ack_o) cnt_wb_ack  <= cnt_wb_ack + 1;
    if (wb_err_o) cnt_wb_err  <= cnt_wb_err + 1;
    if (tcm_req)  cnt_tcm_req <= cnt_tcm_req + 1;
  end

  ycr_tcm_dmem_arb #(.TCM_BASE(TcmBase), .RESP_TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_cmd(core_cmd), .core_width(core_width),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_req_ack(core_req_ack),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .tcm_req(tcm_req), .tcm_cmd(tcm_cmd), .tcm_width(tcm_width), .tcm_addr(tcm_addr),
    .tcm_wdata(tcm_wdata), .tcm_req_ack(tcm_req_ack), .tcm_rdata(tcm_rdata),
    .tcm_resp(tcm_resp)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    core_req = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_sel_i = 4'hF;
    rst = 1'b1;
    tick(3);
    n_chk++;
    if ({tcm_req, core_req_ack, wb_ack_o, wb_err_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses got %b want 0000",
                         {tcm_req, core_req_ack, wb_ack_o, wb_err_o});
    end
    n_chk++;
    if (core_resp !== 2'b00) begin
      n_fail++; $display("FAIL reset_core_resp got %b want 00", core_resp);
    end
    n_chk++;
    if (wb_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_wb_dat got %h want 0", wb_dat_o);
    end
    core_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_core_read();
    int ack0;
    ack0 = cnt_wb_ack + cnt_wb_err;
    tb_rdata = 32'hDEAD_BEEF; tb_code = 2'b01;
    core_req = 1'b1; core_cmd = 1'b0; core_width = 2'd2; core_addr = 32'h0000_0804;
    n_chk++;
    if (core_req_ack !== 1'b0) begin
      n_fail++; $display("FAIL core_ack_early got %b want 0", core_req_ack);
    end
    tick();
    n_chk++;
    if ({core_req_ack, tcm_req, tcm_cmd, tcm_width} !== 5'b11010) begin
      n_fail++; $display("FAIL core_req_phase got %b want 11010",
                         {core_req_ack, tcm_req, tcm_cmd, tcm_width});
    end
    n_chk++;
    if (tcm_addr !== 32'h0000_0804) begin
      n_fail++; $display("FAIL core_tcm_addr got %h want 00000804", tcm_addr);
    end
    tick();
    core_req = 1'b0;
    n_chk++;
    if (core_resp !== 2'b00 || core_req_ack !== 1'b0) begin
      n_fail++; $display("FAIL core_wait got resp %b ack %b want 00 0", core_resp, core_req_ack);
    end
    tick();
    n_chk++;
    if (core_resp !== 2'b01 || core_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL core_rdata got %b %h want 01 deadbeef", core_resp, core_rdata);
    end
    tick();
    n_chk++;
    if (core_resp !== 2'b00 || tcm_req !== 1'b0 || (cnt_wb_ack + cnt_wb_err) !== ack0) begin
      n_fail++; $display("FAIL core_done got resp %b req %b wb %0d want 00 0 %0d",
                         core_resp, tcm_req, cnt_wb_ack + cnt_wb_err, ack0);
    end
  endtask

  task automatic test_wb_byte_write();
    int ack0;
    ack0 = cnt_wb_ack;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_sel_i = 4'b0100; wb_adr_i = 32'h0000_0010; wb_dat_i = 32'h00AB_0000;
    tick();
    n_chk++;
    if ({tcm_req, tcm_cmd, tcm_width} !== 4'b1100) begin
      n_fail++; $display("FAIL wbw_ctrl got %b want 1100", {tcm_req, tcm_cmd, tcm_width});
    end
    n_chk++;
    if (tcm_addr !== (TcmBase | 32'h12)) begin
      n_fail++; $display("FAIL wbw_addr got %h want %h", tcm_addr, TcmBase | 32'h12);
    end
    n_chk++;
    if (tcm_wdata[7:0] !== 8'hAB) begin
      n_fail++; $display("FAIL wbw_wdata got %h want ab", tcm_wdata[7:0]);
    end
    tick(2);
    n_chk++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL wbw_ack_early got %b want 0", wb_ack_o);
    end
    tick();
    n_chk++;
    if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin
      n_fail++; $display("FAIL wbw_ack got ack %b err %b want 1 0", wb_ack_o, wb_err_o);
    end
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick(2);
    n_chk++;
    if (cnt_wb_ack - ack0 !== 1) begin
      n_fail++; $display("FAIL wbw_ack_count got %0d want 1", cnt_wb_ack - ack0);
    end
  endtask

  task automatic test_wb_hword_read();
    tb_rdata = 32'h0000_1234;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'b1100; wb_adr_i = 32'h0000_0020;
    tick();
    n_chk++;
    if ({tcm_req, tcm_cmd, tcm_width} !== 4'b1001 || tcm_addr !== (TcmBase | 32'h22)) begin
      n_fail++; $display("FAIL wbh_req got %b %h want 1001 %h",
                         {tcm_req, tcm_cmd, tcm_width}, tcm_addr, TcmBase | 32'h22);
    end
    tick(3);
    n_chk++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1234_0000) begin
      n_fail++; $display("FAIL wbh_ack got %b %h want 1 12340000", wb_ack_o, wb_dat_o);
    end
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tb_rdata = 32'h0;
    tick();
    n_chk++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h1234_0000) begin
      n_fail++; $display("FAIL wbh_hold got %b %h want 0 12340000", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    n_chk++;
    if (wb_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL rr_reset_dat got %h want 0", wb_dat_o);
    end
    tb_rdata = 32'h1111_2222;
    core_req = 1'b1; core_cmd = 1'b0; core_width = 2'd2; core_addr = 32'h0000_0100;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'b1111; wb_adr_i = 32'h0000_0040;
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      n_chk++;
      if (tcm_req !== 1'b1 || core_req_ack !== 1'b0 || tcm_addr !== (TcmBase | 32'h40)) begin
        n_fail++; $display("FAIL rr_wb_first%0d got req %b cack %b addr %h want 1 0 %h",
                           pass, tcm_req, core_req_ack, tcm_addr, TcmBase | 32'h40);
      end
      tick(3);
      n_chk++;
      if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1111_2222) begin
        n_fail++; $display("FAIL rr_wb_ack%0d got %b %h want 1 11112222", pass, wb_ack_o,
                           wb_dat_o);
      end
      tick();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      n_chk++;
      if (core_req_ack !== 1'b1 || tcm_addr !== 32'h0000_0100) begin
        n_fail++; $display("FAIL rr_core_next%0d got %b %h want 1 00000100", pass,
                           core_req_ack, tcm_addr);
      end
      tick();
      core_req = 1'b0;
      tick();
      n_chk++;
      if (core_resp !== 2'b01) begin
        n_fail++; $display("FAIL rr_core_resp%0d got %b want 01", pass, core_resp);
      end
      tick();
      core_req = 1'b1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    end
    core_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(2);
  endtask

  task automatic test_bad_sel();
    int req0, err0;
    req0 = cnt_tcm_req; err0 = cnt_wb_err;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'b0101;
    tick();
    n_chk++;
    if ({wb_err_o, wb_ack_o, tcm_req} !== 3'b100) begin
      n_fail++; $display("FAIL badsel_err got %b want 100", {wb_err_o, wb_ack_o, tcm_req});
    end
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick(2);
    n_chk++;
    if (cnt_wb_err - err0 !== 1 || cnt_tcm_req !== req0) begin
      n_fail++; $display("FAIL badsel_counts got err %0d req %0d want 1 0",
                         cnt_wb_err - err0, cnt_tcm_req - req0);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    tb_resp_en = 1'b0;
    core_req = 1'b1; core_cmd = 1'b0; core_width = 2'd2; core_addr = 32'h0000_0200;
    tick();
    n_chk++;
    if (core_req_ack !== 1'b1) begin
      n_fail++; $display("FAIL to_ack got %b want 1", core_req_ack);
    end
    tick();
    core_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (core_resp !== 2'b00) early++;
      tick();
    end
    n_chk++;
    if (early !== 0) begin
      n_fail++; $display("FAIL to_early got %0d nonzero cycles want 0", early);
    end
    n_chk++;
    if (core_resp !== 2'b10) begin
      n_fail++; $display("FAIL to_err got %b want 10", core_resp);
    end
    tick();
    n_chk++;
    if (core_resp !== 2'b00 || tcm_req !== 1'b0) begin
      n_fail++; $display("FAIL to_idle got %b %b want 00 0", core_resp, tcm_req);
    end
    tb_late = 1'b1;
    tick();
    tb_late = 1'b0;
    n_chk++;
    if ({core_resp, tcm_req, wb_ack_o, wb_err_o} !== 5'b00000) begin
      n_fail++; $display("FAIL to_late got %b want 00000",
                         {core_resp, tcm_req, wb_ack_o, wb_err_o});
    end
    tb_resp_en = 1'b1; tb_rdata = 32'hCAFE_F00D;
    core_req = 1'b1; core_addr = 32'h0000_0300;
    tick();
    n_chk++;
    if (core_req_ack !== 1'b1 || tcm_addr !== 32'h0000_0300) begin
      n_fail++; $display("FAIL to_next_ack got %b %h want 1 00000300", core_req_ack, tcm_addr);
    end
    tick();
    core_req = 1'b0;
    tick();
    n_chk++;
    if (core_resp !== 2'b01 || core_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL to_next_resp got %b %h want 01 cafef00d", core_resp, core_rdata);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    tb_resp_en = 1'b0;
    core_req = 1'b1; core_addr = 32'h0000_0400;
    tick(2);
    core_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({core_resp, tcm_req, core_req_ack, wb_ack_o, wb_err_o} !== 6'b000000) begin
      n_fail++; $display("FAIL midrst got %b want 000000",
                         {core_resp, tcm_req, core_req_ack, wb_ack_o, wb_err_o});
    end
    tb_resp_en = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_wb_byte_write();
    test_wb_hword_read();
    test_round_robin();
    test_bad_sel();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
